pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised, pipelined add/subtract unit; next generation of our combinational ripple adder.
//  WIDTH-bit operands are split into STAGES equal chunks; one chunk resolves per clock with the carry
//  registered between stages, so clock rate is independent of WIDTH. Valid/ready on both sides,
//  1 op/cycle throughput. Sits between operand producers and result consumers in datapath pipelines.
// PARAMETERS
//  WIDTH   16  operand/result width in bits; must be a multiple of STAGES
//  STAGES   4  pipeline depth = latency in cycles; CHUNK = WIDTH/STAGES (localparam), 1 <= STAGES <= WIDTH
// PORTS
//  clk        in   1      clock, all flops rising-edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit can accept a beat this cycle
//  A          in   WIDTH  operand A (unsigned or two's complement)
//  B          in   WIDTH  operand B
//  Cin        in   1      carry-in; used only when Sub=0
//  Sub        in   1      0: A+B+Cin; 1: A-B (A+~B+1, Cin ignored)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result
//  Sum        out  WIDTH  result
//  Cout       out  1      carry out of MSB (Sub=1: 1 = no borrow)
//  Overflow   out  1      signed overflow = carry into MSB ^ carry out of MSB
// BEHAVIOUR
//  - Reset (rst_n low, async): all stage valids, out_valid, Sum, Cout, Overflow -> 0; in_ready = 0 while
//    rst_n low. In-flight ops discarded; nothing stale appears after release. in_ready = 1 first cycle after.
//  - advance = ~out_valid | out_ready; in_ready = advance (when out of reset). Whole pipe shifts on advance;
//    bubbles travel as invalid stages. Accept iff in_valid & in_ready.
//  - Stage k (0..STAGES-1) adds chunk k of A and B' (B' = Sub ? ~B : B) with carry from stage k-1
//    register (stage 0 carry-in = Sub ? 1 : Cin). Upper operand chunks are skew-delayed; resolved lower
//    chunks are deskew-delayed so all WIDTH bits of Sum present in the same cycle.
//  - Latency: op accepted at edge t -> out_valid with its result after edge t+STAGES-1 (STAGES cycles).
//  - Stall: out_valid & ~out_ready -> Sum/Cout/Overflow/out_valid held stable, in_ready = 0, no op lost.
//  - Simultaneous out handshake and new accept in the same cycle: both occur, full throughput.
//  - Arithmetic wraps modulo 2^WIDTH; results identical to ideal WIDTH+1-bit sum {Cout,Sum}.
//  - STAGES=1: single registered adder, latency 1.
//  - Results leave strictly in acceptance order.
// CONFIGURATION
//  ADDER_SAT_EN defined: Sum saturates unsigned: Sub=0 & Cout=1 -> all-ones; Sub=1 & Cout=0 -> zero.
//    Cout and Overflow still report raw (unsaturated) status. Clamp applied in final stage, no added latency.
//  ADDER_SAT_EN undefined: Sum wraps; no clamp logic instantiated.
// STRUCTURE
//  - Shared package adder_pkg: mode encodings (OP_ADD=1'b0, OP_SUB=1'b1), CHUNK derivation function,
//    WIDTH%STAGES legality check constant.
//  - One sub-module: adder_stage (CHUNK-bit ripple slice built from full_adder, ports a, b, cin, sum,
//    cout, c_msb_in for overflow detect); instantiated STAGES times via generate. Registers live in top.
// TESTING (WIDTH=16, STAGES=4 unless noted)
//  1. rst_n low -> out_valid=0, Sum=0, in_ready=0; release -> in_ready=1 next cycle.
//  2. A=FFFF B=0001 Cin=0 Sub=0 -> 4 cycles later Sum=0000 Cout=1 Overflow=0 (SAT_EN: Sum=FFFF).
//  3. A=0005 B=0007 Sub=1 -> Sum=FFFE Cout=0 Overflow=0 (SAT_EN: Sum=0000).
//  4. A=7FFF B=0001 Sub=0 Cin=0 -> Sum=8000 Cout=0 Overflow=1; A=0006 B=000B Cin=1 -> Sum=0012.
//  5. 8 back-to-back ops, out_ready low 3 cycles mid-stream -> all 8 results in order, outputs stable
//     and in_ready=0 during stall, no duplicate/loss; then 1 result/cycle resumes.
//  6. Assert rst_n with 3 ops in flight -> out_valid drops immediately, no stale result after release;
//     also rerun 2-4 with STAGES=1 and WIDTH=4,STAGES=2 against a behavioural {Cout,Sum} model.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit:
// operation encodings and configuration helpers.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int chunk_w(input int w, input int s);
    return w / s;
  endfunction

  function automatic bit cfg_ok(input int w, input int s);
    return (s >= 1) && (s <= w) && ((w % s) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// master = operand producer and result consumer, slave = the adder.
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Overflow;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Overflow
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Overflow
  );

endinterface

// File: rtl/adder_stage.sv
// One combinational ripple slice of the pipelined adder,
// built from single-bit full adders.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module adder_stage #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout     = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit, one CHUNK-bit slice per stage.
// ADDER_SAT_EN: clamp Sum to unsigned range in the final stage.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_adder_if.slave bus
);

  localparam bit CFG_OK = cfg_ok(WIDTH, STAGES);
  localparam int CHUNK  = CFG_OK ? chunk_w(WIDTH, STAGES) : 0;

  logic             advance;
  logic             accept;

  logic             vi [STAGES];
  logic             ci [STAGES];
  logic             co [STAGES];
  logic             cm [STAGES];
  logic [WIDTH-1:0] ai [STAGES];
  logic [WIDTH-1:0] bi [STAGES];
  logic [WIDTH-1:0] si [STAGES];
  logic [WIDTH-1:0] sn [STAGES];
  logic [CHUNK-1:0] cs [STAGES];

  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             ov_q;
  logic [WIDTH-1:0] fin;

`ifdef ADDER_SAT_EN
  logic             subi  [STAGES];
  logic             sub_q [STAGES];
`endif

  assign advance       = !v_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready  = rst_n && advance;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.Sum       = s_q[STAGES-1];
  assign bus.Cout      = c_q[STAGES-1];
  assign bus.Overflow  = ov_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    if (k == 0) begin : g_in
      // Subtract is A + ~B + 1; the +1 rides in on the stage-0 carry
      assign vi[0] = accept;
      assign ai[0] = bus.A;
      assign bi[0] = (bus.Sub == OP_SUB) ? ~bus.B : bus.B;
      assign ci[0] = (bus.Sub == OP_SUB) ? 1'b1 : bus.Cin;
      assign si[0] = '0;
`ifdef ADDER_SAT_EN
      assign subi[0] = bus.Sub;
`endif
    end else begin : g_chain
      assign vi[k] = v_q[k-1];
      assign ai[k] = a_q[k-1];
      assign bi[k] = b_q[k-1];
      assign ci[k] = c_q[k-1];
      assign si[k] = s_q[k-1];
`ifdef ADDER_SAT_EN
      assign subi[k] = sub_q[k-1];
`endif
    end

    adder_stage #(
      .W (CHUNK)
    ) u_stage (
      .a        (ai[k][k*CHUNK +: CHUNK]),
      .b        (bi[k][k*CHUNK +: CHUNK]),
      .cin      (ci[k]),
      .sum      (cs[k]),
      .cout     (co[k]),
      .c_msb_in (cm[k])
    );

    assign sn[k] = si[k] | (WIDTH'(cs[k]) << (k * CHUNK));
  end

  always_comb begin
    fin = sn[STAGES-1];
`ifdef ADDER_SAT_EN
    if (subi[STAGES-1] == OP_ADD && co[STAGES-1])
      fin = '1;
    else if (subi[STAGES-1] == OP_SUB && !co[STAGES-1])
      fin = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
`ifdef ADDER_SAT_EN
        sub_q[k] <= 1'b0;
`endif
      end
      ov_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= vi[k];
        c_q[k] <= co[k];
        a_q[k] <= ai[k];
        b_q[k] <= bi[k];
        s_q[k] <= (k == STAGES - 1) ? fin : sn[k];
`ifdef ADDER_SAT_EN
        sub_q[k] <= subi[k];
`endif
      end
      ov_q <= cm[STAGES-1] ^ co[STAGES-1];
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: 16/4 main unit plus
// 16/1 and 4/2 variants checked against a behavioural model.
module tb_pipelined_adder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pipelined_adder_if #(.WIDTH(16)) bus16 ();
  pipelined_adder_if #(.WIDTH(16)) bus1 ();
  pipelined_adder_if #(.WIDTH(4))  bus4 ();

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  pipelined_adder #(.WIDTH(16), .STAGES(1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  pipelined_adder #(.WIDTH(4), .STAGES(2)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {Overflow, Cout, Sum} of an ideal w-bit adder, sum zero-extended
  function automatic logic [17:0] model(input int w, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin,
                                        input logic sub);
    logic [16:0] m;
    logic [16:0] full;
    logic [15:0] bb;
    logic [15:0] s;
    logic        c;
    logic        o;
    m    = (17'h1 << w) - 17'h1;
    bb   = sub ? ~b : b;
    full = ({1'b0, a} & m) + ({1'b0, bb} & m) + {16'h0, (sub ? 1'b1 : cin)};
    s    = full[15:0] & m[15:0];
    c    = full[w];
    o    = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
`ifdef ADDER_SAT_EN
    if (!sub && c) s = m[15:0];
    else if (sub && !c) s = '0;
`endif
    return {o, c, s};
  endfunction

  task automatic idle_all;
    bus16.in_valid = 0; bus16.out_ready = 1;
    bus16.A = '0; bus16.B = '0; bus16.Cin = 0; bus16.Sub = 0;
    bus1.in_valid = 0; bus1.out_ready = 1;
    bus1.A = '0; bus1.B = '0; bus1.Cin = 0; bus1.Sub = 0;
    bus4.in_valid = 0; bus4.out_ready = 1;
    bus4.A = '0; bus4.B = '0; bus4.Cin = 0; bus4.Sub = 0;
  endtask

  task automatic send16(input string nm, input logic [15:0] a,
                        input logic [15:0] b, input logic cin,
                        input logic sub, input logic [15:0] es,
                        input logic ec, input logic eo);
    int cnt;
    @(posedge clk); #1;
    bus16.in_valid = 1; bus16.out_ready = 1;
    bus16.A = a; bus16.B = b; bus16.Cin = cin; bus16.Sub = sub;
    @(negedge clk);
    checks++;
    if (bus16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_in_ready: got %b exp 1", nm, bus16.in_ready);
    end
    @(posedge clk); #1;
    bus16.in_valid = 0;
    cnt = 0;
    while (bus16.out_valid !== 1'b1 && cnt < 12) begin
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    if (cnt !== 3) begin
      errors++;
      $display("FAIL %s_latency: got %0d exp 3", nm, cnt);
    end
    checks++;
    if (bus16.Sum !== es) begin
      errors++;
      $display("FAIL %s_sum: got %h exp %h", nm, bus16.Sum, es);
    end
    checks++;
    if (bus16.Cout !== ec) begin
      errors++;
      $display("FAIL %s_cout: got %b exp %b", nm, bus16.Cout, ec);
    end
    checks++;
    if (bus16.Overflow !== eo) begin
      errors++;
      $display("FAIL %s_ovf: got %b exp %b", nm, bus16.Overflow, eo);
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid: got %b exp 0", bus16.out_valid);
    end
    checks++;
    if (bus16.Sum !== 16'h0) begin
      errors++;
      $display("FAIL rst_sum: got %h exp 0000", bus16.Sum);
    end
    checks++;
    if (bus16.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_ready: got %b exp 0", bus16.in_ready);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (bus16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rel_in_ready: got %b exp 1", bus16.in_ready);
    end
  endtask

  task automatic test_add_wrap;
`ifdef ADDER_SAT_EN
    send16("add_wrap", 16'hFFFF, 16'h0001, 0, 0, 16'hFFFF, 1, 0);
`else
    send16("add_wrap", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
`endif
  endtask

  task automatic test_sub;
`ifdef ADDER_SAT_EN
    send16("sub_borrow", 16'h0005, 16'h0007, 0, 1, 16'h0000, 0, 0);
`else
    send16("sub_borrow", 16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
`endif
    send16("sub_cin_ign", 16'h0009, 16'h0003, 1, 1, 16'h0006, 1, 0);
  endtask

  task automatic test_overflow;
    send16("ovf", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
    send16("add_cin", 16'h0006, 16'h000B, 1, 0, 16'h0012, 0, 0);
  endtask

  task automatic test_back_to_back;
    logic [15:0] av [8];
    int idx;
    int ridx;
    int last;
    idx = 0; ridx = 0; last = -1;
    for (int i = 0; i < 8; i++) av[i] = 16'(i) * 16'h2222;
    for (int cyc = 0; cyc < 40 && ridx < 8; cyc++) begin
      @(posedge clk); #1;
      bus16.in_valid  = (idx < 8);
      bus16.A         = av[idx % 8];
      bus16.B         = 16'h0101;
      bus16.Cin       = 0;
      bus16.Sub       = 0;
      bus16.out_ready = !(cyc >= 6 && cyc <= 8);
      @(negedge clk);
      if (bus16.out_valid && !bus16.out_ready) begin
        checks++;
        if (bus16.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready cyc%0d: got %b exp 0", cyc, bus16.in_ready);
        end
        checks++;
        if (bus16.Sum !== av[ridx] + 16'h0101) begin
          errors++;
          $display("FAIL stall_hold cyc%0d: got %h exp %h", cyc, bus16.Sum,
                   av[ridx] + 16'h0101);
        end
      end
      if (bus16.out_valid && bus16.out_ready) begin
        checks++;
        if (bus16.Sum !== av[ridx] + 16'h0101) begin
          errors++;
          $display("FAIL b2b_sum%0d: got %h exp %h", ridx, bus16.Sum,
                   av[ridx] + 16'h0101);
        end
        ridx++;
        last = cyc;
      end
      if (bus16.in_valid && bus16.in_ready) idx++;
    end
    @(posedge clk); #1;
    bus16.in_valid = 0; bus16.out_ready = 1;
    checks++;
    if (ridx !== 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d exp 8", ridx);
    end
    checks++;
    if (last !== 14) begin
      errors++;
      $display("FAIL b2b_last_cycle: got %0d exp 14", last);
    end
  endtask

  task automatic test_reset_in_flight;
    int stale;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus16.in_valid = 1; bus16.out_ready = 1;
      bus16.A = 16'h0100 * 16'(i + 1); bus16.B = 16'h0001;
      bus16.Cin = 0; bus16.Sub = 0;
    end
    @(posedge clk); #1;
    bus16.in_valid = 0;
    checks++;
    if (bus16.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flight_pre_valid: got %b exp 1", bus16.out_valid);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (bus16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flight_async_valid: got %b exp 0", bus16.out_valid);
    end
    checks++;
    if (bus16.Sum !== 16'h0) begin
      errors++;
      $display("FAIL flight_async_sum: got %h exp 0000", bus16.Sum);
    end
    @(negedge clk);
    rst_n = 1;
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus16.out_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL flight_stale: got %0d valid beats exp 0", stale);
    end
    send16("post_rst", 16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0);
  endtask

  task automatic test_configs;
    logic [15:0] va [5];
    logic [15:0] vb [5];
    logic [3:0]  wa [5];
    logic [3:0]  wb [5];
    logic        vc [5];
    logic        vs [5];
    logic [17:0] exp;
    va = '{16'hFFFF, 16'h0005, 16'h7FFF, 16'h0006, 16'h0009};
    vb = '{16'h0001, 16'h0007, 16'h0001, 16'h000B, 16'h0003};
    wa = '{4'hF, 4'h5, 4'h7, 4'h6, 4'h9};
    wb = '{4'h1, 4'h7, 4'h1, 4'hB, 4'h3};
    vc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus1.in_valid = 1; bus1.A = va[i]; bus1.B = vb[i];
      bus1.Cin = vc[i]; bus1.Sub = vs[i];
      bus4.in_valid = 1; bus4.A = wa[i]; bus4.B = wb[i];
      bus4.Cin = vc[i]; bus4.Sub = vs[i];
      @(posedge clk); #1;
      bus1.in_valid = 0; bus4.in_valid = 0;
      exp = model(16, va[i], vb[i], vc[i], vs[i]);
      checks++;
      if (bus1.out_valid !== 1'b1 ||
          {bus1.Overflow, bus1.Cout, bus1.Sum} !== exp) begin
        errors++;
        $display("FAIL s1_vec%0d: got v=%b %b%b_%h exp v=1 %h", i,
                 bus1.out_valid, bus1.Overflow, bus1.Cout, bus1.Sum, exp);
      end
      @(posedge clk); #1;
      exp = model(4, {12'h0, wa[i]}, {12'h0, wb[i]}, vc[i], vs[i]);
      checks++;
      if (bus4.out_valid !== 1'b1 ||
          {bus4.Overflow, bus4.Cout, 12'h0, bus4.Sum} !== exp) begin
        errors++;
        $display("FAIL w4s2_vec%0d: got v=%b %b%b_%h exp v=1 %h", i,
                 bus4.out_valid, bus4.Overflow, bus4.Cout, bus4.Sum, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1;
    idle_all();
    test_reset();
    test_add_wrap();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_reset_in_flight();
    test_configs();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
